// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the adder pipeline and its accumulator stage.
// Holds FSM state encodings and default datapath widths.
package adder_pipe_pkg;

    localparam int SUM_W_DEF = 17;
    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The stage can take a sum in every state except HOLD.
    function automatic logic accepts(input state_t s);
        return (s == IDLE) || (s == ACCUM);
    endfunction

endpackage

// File: rtl/sum_accum_stage_if.sv
// Handshake bundle between the adder stage, the accumulator and readout.
// master drives sums and out_ready; slave is the accumulator stage.
interface sum_accum_stage_if
    import adder_pipe_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] sum_in;
    logic [LEN_W-1:0] blk_len;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;

    modport master (
        output in_valid,
        output sum_in,
        output blk_len,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  sum_in,
        input  blk_len,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out,
        output ovf
    );

endinterface

// File: rtl/sum_accum_stage_acc_add_sat.sv
// Combinational accumulator adder: acc + zero-extended sum, with carry.
// Build option ACC_SATURATE_EN clamps the result to all-ones on carry.
module acc_add_sat
    import adder_pipe_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SUM_W-1:0] addend,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] raw;

    // Widen by one bit so the carry out of the top bit is visible.
    always_comb begin
        raw   = {1'b0, acc} + (ACC_W + 1)'(addend);
        carry = raw[ACC_W];
`ifdef ACC_SATURATE_EN
        // A clamped all-ones acc carries again on any nonzero addend,
        // so it stays pinned for the rest of the block.
        sum   = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
        sum   = raw[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accum_stage.sv
// Block accumulator behind the adder: sums blk_len beats, presents total.
// Option macro ACC_SATURATE_EN: saturate on overflow instead of wrapping.
module sum_accum_stage
    import adder_pipe_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    sum_accum_stage_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic             ready_q;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             ovf_q;

    logic             beat;
    logic             last_acc;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] cnt_inc;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    acc_add_sat #(
        .SUM_W (SUM_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc    (acc),
        .addend (bus.sum_in),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    // Beat qualification, length latch value and block-end detect.
    always_comb begin
        beat     = bus.in_valid && ready_q;
        len_eff  = (bus.blk_len == '0) ? LEN_W'(1) : bus.blk_len;
        cnt_inc  = cnt + LEN_W'(1);
        last_acc = (cnt_inc == len_q);
    end

    // State register; in_ready is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= accepts(state_nx);
        end
    end

    // Next-state logic; clr overrides any beat or transfer.
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (beat) begin
                        state_nx = (len_eff == LEN_W'(1)) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat && last_acc) begin
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output decode: totals are presented only while holding.
    always_comb begin
        bus.in_ready  = ready_q;
        bus.out_valid = (state == HOLD);
        bus.acc_out   = acc;
        bus.ovf       = ovf_q;
    end

    // Accumulator, beat counter, latched length and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (beat) begin
                        acc   <= ACC_W'(bus.sum_in);
                        len_q <= len_eff;
                        cnt   <= LEN_W'(1);
                        ovf_q <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= add_sum;
                        cnt   <= cnt_inc;
                        ovf_q <= ovf_q | add_carry;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        ovf_q <= 1'b0;
                    end
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum_stage.sv
// Randomized bench for sum_accum_stage against a block-sum reference.
// Directed cases cover reset, blk_len=0, back-pressure, overflow, clr.
module tb_sum_accum_stage;
    import adder_pipe_pkg::*;

    localparam int SW = 17;
    localparam int AW = 24;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sum_accum_stage_if #(.SUM_W(SW), .ACC_W(AW), .LEN_W(LW)) bus ();

    sum_accum_stage #(
        .SUM_W (SW),
        .ACC_W (AW),
        .LEN_W (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact block sum in wide arithmetic, then wrap or clamp.
    function automatic logic [AW:0] model(input int unsigned q[$]);
        longint        t;
        logic          o;
        logic [AW-1:0] v;
        t = 0;
        foreach (q[i]) t += longint'(q[i]);
        o = (t >= (longint'(1) << AW));
        v = t[AW-1:0];
`ifdef ACC_SATURATE_EN
        if (o) v = '1;
`endif
        return {o, v};
    endfunction

    // Present one sum and wait for it to be accepted.
    task automatic push(input logic [SW-1:0] s, input logic [LW-1:0] bl);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.sum_in   = s;
        bus.blk_len  = bl;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("push_timeout", 32'(n), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait for a total, stall for a while, then take it.
    task automatic pull(input logic [AW:0] exp, input int stall,
                        input string tag);
        int n;
        n = 0;
        bus.out_ready = 1'b0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_acc"}, 32'(bus.acc_out), 32'(exp[AW-1:0]));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp[AW]));
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, "_stall_acc"}, 32'(bus.acc_out), 32'(exp[AW-1:0]));
            check({tag, "_stall_ovf"}, 32'(bus.ovf), 32'(exp[AW]));
            check({tag, "_stall_vld"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_stall_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post_vld"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_rdy"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_post_ovf"}, 32'(bus.ovf), 32'd0);
    endtask

    // Feed a whole block; blk_len is only honoured on the first beat.
    task automatic run_block(input logic [LW-1:0] bl, input int unsigned q[$],
                             input logic [AW:0] exp, input bit gaps,
                             input int stall, input string tag);
        foreach (q[i]) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            push(SW'(q[i]), (i == 0) ? bl : LW'($urandom));
            if (i < q.size() - 1) begin
                check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
            end
        end
        check({tag, "_lat"}, 32'(bus.out_valid), 32'd1);
        pull(exp, stall, tag);
    endtask

    initial begin
        int unsigned q[$];
        int          len;
        logic [AW:0] ovf_exp;

        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.blk_len   = '0;
        bus.out_ready = 1'b0;

        #1;
        check("rst_rdy", 32'(bus.in_ready), 32'd0);
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        check("rst_acc", 32'(bus.acc_out), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rdy", 32'(bus.in_ready), 32'd1);

        // Basic 4-beat block.
        q = {};
        q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(32'h1FFFF);
        run_block(8'd4, q, {1'b0, 24'h020005}, 1'b0, 0, "basic");

        // Zero length behaves as length one.
        q = {};
        q.push_back(32'h10);
        run_block(8'd0, q, {1'b0, 24'h000010}, 1'b0, 0, "len0");

        // Back-pressure for 5 cycles.
        q = {};
        q.push_back(100); q.push_back(200); q.push_back(300);
        run_block(8'd3, q, {1'b0, 24'd600}, 1'b0, 5, "bp");

        // Reset in the middle of accumulating.
        push(17'd1, 8'd4);
        push(17'd2, 8'd4);
        push(17'd3, 8'd4);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        check("mid_rst_acc", 32'(bus.acc_out), 32'd0);
        check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        check("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        q = {};
        q.push_back(5); q.push_back(7);
        run_block(8'd2, q, {1'b0, 24'd12}, 1'b0, 0, "after_rst");

        // clr on the third beat of a 4-beat block.
        push(17'd1, 8'd4);
        push(17'd2, 8'd4);
        bus.in_valid = 1'b1;
        bus.sum_in   = 17'd3;
        clr          = 1'b1;
        @(negedge clk);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_vld", 32'(bus.out_valid), 32'd0);
        check("clr_rdy", 32'(bus.in_ready), 32'd1);
        check("clr_acc", 32'(bus.acc_out), 32'd0);
        repeat (3) @(negedge clk);
        check("clr_still_idle", 32'(bus.out_valid), 32'd0);
        q = {};
        q.push_back(9); q.push_back(9);
        run_block(8'd2, q, {1'b0, 24'd18}, 1'b0, 0, "after_clr");

        // clr while holding a total drops it.
        push(17'd44, 8'd1);
        check("hold_vld", 32'(bus.out_valid), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_hold_vld", 32'(bus.out_valid), 32'd0);
        check("clr_hold_rdy", 32'(bus.in_ready), 32'd1);

        // Full-length overflow block.
`ifdef ACC_SATURATE_EN
        ovf_exp = {1'b1, 24'hFFFFFF};
`else
        ovf_exp = {1'b1, 24'hFDFF01};
`endif
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(32'h1FFFF);
        run_block(8'd255, q, ovf_exp, 1'b0, 2, "ovf");

        // Randomized blocks against the reference.
        for (int b = 0; b < 30; b++) begin
            logic [LW-1:0] bl;
            bl  = (b == 29) ? LW'(200) : LW'($urandom_range(0, 12));
            len = (bl == 0) ? 1 : int'(bl);
            q = {};
            for (int i = 0; i < len; i++) begin
                if (b == 29 || $urandom_range(0, 3) == 0) q.push_back(32'h1FFFF);
                else q.push_back($urandom & 32'h1FFFF);
            end
            run_block(bl, q, model(q), 1'b1, $urandom_range(0, 3), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end

endmodule
